// File: rtl/tod_pkg.sv
// Shared types, limits and arithmetic helpers for the time-of-day counter.
package tod_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_HOURS = 2'd1,
    SET_MINS  = 2'd2
  } tod_state_t;

  localparam logic [7:0] HOURS_MAX = 8'd23;
  localparam logic [7:0] MINS_MAX  = 8'd59;
  localparam logic [7:0] SECS_MAX  = 8'd59;

  // Compare-to-max then clear, so a field can never leave its legal range.
  function automatic logic [7:0] inc_wrap(input logic [7:0] val, input logic [7:0] max);
    if (val >= max) begin
      return 8'd0;
    end else begin
      return val + 8'd1;
    end
  endfunction

  function automatic logic [7:0] to_bcd(input logic [7:0] val);
    return {4'(val / 8'd10), 4'(val % 8'd10)};
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for one debounced button level; pulse is high for the
// single cycle in which the level is first sampled high.
module edge_pulse (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic pulse
);

  logic btn_q_r;

  // One-cycle history of the button level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q_r <= 1'b0;
    end else begin
      btn_q_r <= btn;
    end
  end

  assign pulse = btn & ~btn_q_r;

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour binary time-of-day counter with 1 Hz prescaler and button set mode.
// Define TOD_BCD_OUT_EN to add registered packed-BCD hours/minutes outputs.
module time_of_day_counter
  import tod_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_set_time,
  input  logic       btn_inc_hours,
  input  logic       btn_inc_mins,
  output logic [7:0] real_hours,
  output logic [7:0] real_mins,
  output logic [7:0] real_secs,
  output logic       sec_tick,
  output logic       setting_active
`ifdef TOD_BCD_OUT_EN
  ,
  output logic [7:0] hours_bcd,
  output logic [7:0] mins_bcd
`endif
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  tod_state_t    state_r, state_nxt_s;
  logic [PW-1:0] presc_r, presc_nxt_s;
  logic          sec_tick_r, tick_nxt_s;
  logic [7:0]    hours_r, hours_nxt_s;
  logic [7:0]    mins_r, mins_nxt_s;
  logic [7:0]    secs_r, secs_nxt_s;
  logic          set_ev_s, inc_h_ev_s, inc_m_ev_s;

  edge_pulse u_set_edge (.clk(clk), .reset_n(reset_n), .btn(btn_set_time),  .pulse(set_ev_s));
  edge_pulse u_hrs_edge (.clk(clk), .reset_n(reset_n), .btn(btn_inc_hours), .pulse(inc_h_ev_s));
  edge_pulse u_min_edge (.clk(clk), .reset_n(reset_n), .btn(btn_inc_mins),  .pulse(inc_m_ev_s));

  // Next-state, prescaler and time arithmetic for all three modes.
  always_comb begin
    state_nxt_s = state_r;
    presc_nxt_s = presc_r;
    tick_nxt_s  = 1'b0;
    hours_nxt_s = hours_r;
    mins_nxt_s  = mins_r;
    secs_nxt_s  = secs_r;
    case (state_r)
      RUN: begin
        // A tick is suppressed if we are about to leave RUN, so none leaks into set mode.
        if (presc_r == PRESC_MAX) begin
          presc_nxt_s = '0;
          tick_nxt_s  = ~set_ev_s;
        end else begin
          presc_nxt_s = presc_r + PW'(1);
          tick_nxt_s  = 1'b0;
        end
        if (sec_tick_r) begin
          secs_nxt_s = inc_wrap(secs_r, SECS_MAX);
          if (secs_r >= SECS_MAX) begin
            mins_nxt_s = inc_wrap(mins_r, MINS_MAX);
            if (mins_r >= MINS_MAX) begin
              hours_nxt_s = inc_wrap(hours_r, HOURS_MAX);
            end else begin
              hours_nxt_s = hours_r;
            end
          end else begin
            mins_nxt_s = mins_r;
          end
        end else begin
          secs_nxt_s = secs_r;
        end
        if (set_ev_s) begin
          state_nxt_s = SET_HOURS;
        end else begin
          state_nxt_s = RUN;
        end
      end
      SET_HOURS: begin
        if (inc_h_ev_s) begin
          hours_nxt_s = inc_wrap(hours_r, HOURS_MAX);
        end else begin
          hours_nxt_s = hours_r;
        end
        if (set_ev_s) begin
          state_nxt_s = SET_MINS;
        end else begin
          state_nxt_s = SET_HOURS;
        end
      end
      SET_MINS: begin
        if (inc_m_ev_s) begin
          mins_nxt_s = inc_wrap(mins_r, MINS_MAX);
        end else begin
          mins_nxt_s = mins_r;
        end
        if (set_ev_s) begin
          state_nxt_s = RUN;
          secs_nxt_s  = 8'd0;
          presc_nxt_s = '0;
        end else begin
          state_nxt_s = SET_MINS;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // State, prescaler, tick and time registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= RUN;
      presc_r    <= '0;
      sec_tick_r <= 1'b0;
      hours_r    <= 8'd0;
      mins_r     <= 8'd0;
      secs_r     <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      presc_r    <= presc_nxt_s;
      sec_tick_r <= tick_nxt_s;
      hours_r    <= hours_nxt_s;
      mins_r     <= mins_nxt_s;
      secs_r     <= secs_nxt_s;
    end
  end

  assign real_hours     = hours_r;
  assign real_mins      = mins_r;
  assign real_secs      = secs_r;
  assign sec_tick       = sec_tick_r;
  assign setting_active = (state_r != RUN);

`ifdef TOD_BCD_OUT_EN
  logic [7:0] hours_bcd_r, mins_bcd_r;

  // BCD copies computed from the same next values so they change with the binary outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hours_bcd_r <= 8'h00;
      mins_bcd_r  <= 8'h00;
    end else begin
      hours_bcd_r <= to_bcd(hours_nxt_s);
      mins_bcd_r  <= to_bcd(mins_nxt_s);
    end
  end

  assign hours_bcd = hours_bcd_r;
  assign mins_bcd  = mins_bcd_r;
`endif

endmodule
